oflow_core_fsm_registration: RTL and testbench

OFLOW_CORE_FSM_REGISTRATION -- requirements
Module: oflow_core_fsm_registration

---
 rtl/oflow_core_pkg.sv | 24 ++
 rtl/oflow_reg_watchdog.sv | 44 ++++
 rtl/oflow_core_fsm_registration.sv | 192 +++++++++++++++++++
 tb/tb_oflow_core_fsm_registration.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oflow_core_pkg
//  Description : Shared types and default widths for the optical-flow core.
//                Provides the registration FSM state encoding and the default
//                values of PE_NUM, SET_LEN, REMAIN_BBOX_LEN and REG_TIMEOUT.
//  Revision    : 1.0  initial release
// ============================================================================
package oflow_core_pkg;

  localparam int c_PE_NUM_DEFAULT          = 24;
  localparam int c_SET_LEN_DEFAULT         = 8;
  localparam int c_REMAIN_BBOX_LEN_DEFAULT = 5;
  localparam int c_REG_TIMEOUT_DEFAULT     = 255;

  typedef enum logic [1:0] {
    idle_st    = 2'd0,
    wait_fe_st = 2'd1,
    reg_st     = 2'd2,
    done_st    = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/oflow_reg_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : oflow_reg_watchdog
//  Description : Stall watchdog for registration requests. Counts consecutive
//                stalled cycles and flags expiry on the REG_TIMEOUT-th one.
//  Ports       : clk      - rising-edge clock
//                reset_N  - asynchronous active-low reset
//                stall_i  - request valid but not accepted this cycle
//                expire_o - this is the REG_TIMEOUT-th consecutive stall
//  Revision    : 1.0  initial release
// ============================================================================
module oflow_reg_watchdog #(
  parameter int REG_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_N,
  input  logic stall_i,
  output logic expire_o
);

  // The counter only has to hold 0..REG_TIMEOUT-1; expiry fires on the last.
  localparam int c_CNT_W = (REG_TIMEOUT > 1) ? $clog2(REG_TIMEOUT) : 1;

  logic [c_CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = stall_i && (cnt_q == c_CNT_W'(REG_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q + c_CNT_W'(1);
    if (!stall_i || expire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/oflow_core_fsm_registration.sv
`default_nettype none
// ============================================================================
//  Module      : oflow_core_fsm_registration
//  Description : Sequences bbox registration requests for each set of a frame.
//                Waits for feature extraction of a set, issues one valid/ready
//                request per bbox, then pulses done_registration (and
//                done_frame on the last set).
//  Option      : OFLOW_REG_TIMEOUT_EN - adds a stall watchdog; when undefined
//                reg_timeout is constant 0 and stalls wait indefinitely.
//  Ports       : clk, reset_N (async, active low)
//                start_pe, num_of_sets, counter_of_remain_bboxes, done_fe,
//                reg_ready                                      - inputs
//                reg_valid, reg_bbox_idx, counter_set_registration,
//                done_registration, done_frame, busy, reg_timeout - outputs
//  Revision    : 1.0  initial release
// ============================================================================
module oflow_core_fsm_registration
  import oflow_core_pkg::*;
#(
  parameter int PE_NUM          = c_PE_NUM_DEFAULT,
  parameter int SET_LEN         = c_SET_LEN_DEFAULT,
  parameter int REMAIN_BBOX_LEN = c_REMAIN_BBOX_LEN_DEFAULT,
  parameter int REG_TIMEOUT     = c_REG_TIMEOUT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset_N,
  input  logic                        start_pe,
  input  logic [SET_LEN-1:0]          num_of_sets,
  input  logic [REMAIN_BBOX_LEN-1:0]  counter_of_remain_bboxes,
  input  logic                        done_fe,
  input  logic                        reg_ready,
  output logic                        reg_valid,
  output logic [$clog2(PE_NUM)-1:0]   reg_bbox_idx,
  output logic [SET_LEN-1:0]          counter_set_registration,
  output logic                        done_registration,
  output logic                        done_frame,
  output logic                        busy,
  output logic                        reg_timeout
);

  localparam int c_IDX_W = $clog2(PE_NUM);
  localparam int c_ACT_W = $clog2(PE_NUM + 1);

  state_e               state_q, state_d;
  logic [SET_LEN-1:0]   nsets_q, nsets_d;
  logic [SET_LEN-1:0]   set_cnt_q, set_cnt_d;
  logic [c_IDX_W-1:0]   bbox_q, bbox_d;
  logic [c_ACT_W-1:0]   active_q, active_d;
  logic                 pending_q, pending_d;
  logic                 zero_frame_q, zero_frame_d;

  logic                 w_start_acc;
  logic                 w_last_set;
  logic                 w_expire;
  logic [c_ACT_W-1:0]   w_next_act;

  assign w_start_acc = (state_q == idle_st) && start_pe;
  assign w_last_set  = (set_cnt_q == nsets_q - SET_LEN'(1));

  // Only the last set uses the remaining-bbox count; it saturates at PE_NUM.
  always_comb begin
    w_next_act = c_ACT_W'(PE_NUM);
    if (w_last_set && (int'(counter_of_remain_bboxes) < PE_NUM)) begin
      w_next_act = c_ACT_W'(counter_of_remain_bboxes);
    end
  end

`ifdef OFLOW_REG_TIMEOUT_EN
  logic w_stall;
  logic timeout_q, timeout_d;

  assign w_stall = (state_q == reg_st) && !reg_ready;

  oflow_reg_watchdog #(
    .REG_TIMEOUT (REG_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset_N  (reset_N),
    .stall_i  (w_stall),
    .expire_o (w_expire)
  );

  // Sticky until the next accepted start_pe.
  always_comb begin
    timeout_d = timeout_q;
    if (w_start_acc) begin
      timeout_d = 1'b0;
    end else if (w_expire) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign reg_timeout = timeout_q;
`else
  assign w_expire    = 1'b0;
  // Always 0 in this build (REG_TIMEOUT is a non-negative cycle count).
  assign reg_timeout = (REG_TIMEOUT < 0);
`endif

  always_comb begin
    state_d      = state_q;
    nsets_d      = nsets_q;
    set_cnt_d    = set_cnt_q;
    bbox_d       = bbox_q;
    active_d     = active_q;
    zero_frame_d = 1'b0;
    // done_fe is remembered in any busy state, so a pulse that arrives while
    // a previous set is still registering (or in done_st) is not lost.
    pending_d    = pending_q | (done_fe && (state_q != idle_st));

    unique case (state_q)
      idle_st: begin
        if (start_pe) begin
          nsets_d   = num_of_sets;
          set_cnt_d = '0;
          bbox_d    = '0;
          active_d  = '0;
          pending_d = 1'b0;
          if (num_of_sets == '0) begin
            zero_frame_d = 1'b1;
          end else begin
            state_d = wait_fe_st;
          end
        end
      end
      wait_fe_st: begin
        if (done_fe || pending_q) begin
          // The done_fe event is consumed here, whichever state follows.
          pending_d = 1'b0;
          active_d  = w_next_act;
          state_d   = (w_next_act == '0) ? done_st : reg_st;
        end
      end
      reg_st: begin
        if (w_expire) begin
          state_d = done_st;
        end else if (reg_ready) begin
          if (c_ACT_W'(bbox_q) == active_q - c_ACT_W'(1)) begin
            state_d = done_st;
          end else begin
            bbox_d = bbox_q + c_IDX_W'(1);
          end
        end
      end
      done_st: begin
        set_cnt_d = set_cnt_q + SET_LEN'(1);
        bbox_d    = '0;
        state_d   = w_last_set ? idle_st : wait_fe_st;
      end
      default: begin
        state_d = idle_st;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q      <= idle_st;
      nsets_q      <= '0;
      set_cnt_q    <= '0;
      bbox_q       <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      zero_frame_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      nsets_q      <= nsets_d;
      set_cnt_q    <= set_cnt_d;
      bbox_q       <= bbox_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      zero_frame_q <= zero_frame_d;
    end
  end

  assign reg_valid                = (state_q == reg_st);
  assign reg_bbox_idx             = bbox_q;
  assign counter_set_registration = set_cnt_q;
  assign done_registration        = (state_q == done_st);
  assign done_frame               = ((state_q == done_st) && w_last_set) || zero_frame_q;
  assign busy                     = (state_q != idle_st);

endmodule
`default_nettype wire

// File: tb/tb_oflow_core_fsm_registration.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oflow_core_fsm_registration
//  Description : Self-checking bench for oflow_core_fsm_registration.
//                Frame vectors from a table, expected requests queued by a
//                small model and compared as the DUT accepts them, plus
//                hand-written sequences for stalls, pending done_fe, reset
//                abort and the optional watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_oflow_core_fsm_registration;

  localparam int c_PE  = 24;
  localparam int c_SL  = 8;
  localparam int c_RBL = 5;

  logic             clk;
  logic             reset_N;
  logic             start_pe;
  logic [c_SL-1:0]  num_of_sets;
  logic [c_RBL-1:0] counter_of_remain_bboxes;
  logic             done_fe;
  logic             reg_ready;
  logic             reg_valid;
  logic [4:0]       reg_bbox_idx;
  logic [c_SL-1:0]  counter_set_registration;
  logic             done_registration;
  logic             done_frame;
  logic             busy;
  logic             reg_timeout;

  oflow_core_fsm_registration #(
    .PE_NUM          (c_PE),
    .SET_LEN         (c_SL),
    .REMAIN_BBOX_LEN (c_RBL),
    .REG_TIMEOUT     (4)
  ) dut (
    .clk                      (clk),
    .reset_N                  (reset_N),
    .start_pe                 (start_pe),
    .num_of_sets              (num_of_sets),
    .counter_of_remain_bboxes (counter_of_remain_bboxes),
    .done_fe                  (done_fe),
    .reg_ready                (reg_ready),
    .reg_valid                (reg_valid),
    .reg_bbox_idx             (reg_bbox_idx),
    .counter_set_registration (counter_set_registration),
    .done_registration        (done_registration),
    .done_frame               (done_frame),
    .busy                     (busy),
    .reg_timeout              (reg_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [c_SL-1:0] set;
    logic [4:0]      idx;
  } exp_t;

  typedef struct {
    int n;
    int remain;
    int exp_reqs;
    int exp_dreg;
    int exp_frame;
  } vec_t;

  exp_t sb_q[$];
  vec_t vec[6];

  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;
  int   dreg_cnt = 0;
  int   frame_cnt = 0;
  logic prev_dreg = 1'b0;
  logic last_frame_dreg = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: request order for a whole frame.
  task automatic push_frame(input int n, input int remain);
    for (int s = 0; s < n; s++) begin
      int cnt;
      cnt = (s == n - 1) ? ((remain > c_PE) ? c_PE : remain) : c_PE;
      for (int i = 0; i < cnt; i++) begin
        exp_t e;
        e.set = s[c_SL-1:0];
        e.idx = i[4:0];
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic start_frame(input int n, input int remain);
    num_of_sets              = n[c_SL-1:0];
    counter_of_remain_bboxes = remain[c_RBL-1:0];
    start_pe                 = 1'b1;
    tick();
    start_pe                 = 1'b0;
  endtask

  task automatic wait_frame(input int base);
    for (int c = 0; c < 600 && frame_cnt == base; c++) tick();
    tick();
    chk("frame_done", frame_cnt - base, 1);
  endtask

  task automatic wait_idx(input int idx);
    for (int c = 0; c < 300 && !(reg_valid && reg_bbox_idx == idx[4:0]); c++) tick();
    chk("reach_idx", {reg_valid, 3'b0, 3'b0, reg_bbox_idx}, {1'b1, 6'b0, idx[4:0]});
  endtask

  // Monitor / scoreboard consumer, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_N) begin
        if (reg_valid && reg_ready) begin
          req_cnt++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req actual_idx=%0d actual_set=%0d expected=none",
                     reg_bbox_idx, counter_set_registration);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("req_idx", reg_bbox_idx, e.idx);
            chk("req_set", counter_set_registration, e.set);
          end
        end
        if (done_registration) begin
          dreg_cnt++;
          chk("dreg_one_cycle", prev_dreg, 0);
        end
        if (done_frame) begin
          frame_cnt++;
          last_frame_dreg = done_registration;
        end
        prev_dreg = done_registration;
      end else begin
        prev_dreg = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int b_req, b_dreg, b_frame;

    vec[0] = '{n: 2, remain: 5,  exp_reqs: 29, exp_dreg: 2, exp_frame: 1};
    vec[1] = '{n: 1, remain: 0,  exp_reqs: 0,  exp_dreg: 1, exp_frame: 1};
    vec[2] = '{n: 3, remain: 24, exp_reqs: 72, exp_dreg: 3, exp_frame: 1};
    vec[3] = '{n: 1, remain: 31, exp_reqs: 24, exp_dreg: 1, exp_frame: 1};
    vec[4] = '{n: 0, remain: 7,  exp_reqs: 0,  exp_dreg: 0, exp_frame: 1};
    vec[5] = '{n: 2, remain: 1,  exp_reqs: 25, exp_dreg: 2, exp_frame: 1};

    reset_N = 1'b0;
    start_pe = 1'b0;
    num_of_sets = '0;
    counter_of_remain_bboxes = '0;
    done_fe = 1'b0;
    reg_ready = 1'b1;
    #12;
    chk("reset_outputs", {reg_valid, done_registration, done_frame, busy, reg_timeout,
                          reg_bbox_idx, counter_set_registration}, 0);
    tick();
    reset_N = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Table-driven frames: ready always high, done_fe held.
    for (int v = 0; v < 6; v++) begin
      b_req = req_cnt; b_dreg = dreg_cnt; b_frame = frame_cnt;
      push_frame(vec[v].n, vec[v].remain);
      reg_ready = 1'b1;
      done_fe   = 1'b1;
      start_frame(vec[v].n, vec[v].remain);
      wait_frame(b_frame);
      tick();
      chk("vec_reqs", req_cnt - b_req, vec[v].exp_reqs);
      chk("vec_dreg", dreg_cnt - b_dreg, vec[v].exp_dreg);
      chk("vec_frame", frame_cnt - b_frame, vec[v].exp_frame);
      chk("vec_frame_with_dreg", last_frame_dreg, (vec[v].n != 0) ? 1 : 0);
      chk("vec_sb_empty", sb_q.size(), 0);
      chk("vec_busy", busy, 0);
      done_fe = 1'b0;
      tick();
    end

    // Single-cycle done_fe for set 0; done_fe for set 1 only in done_st.
    b_dreg = dreg_cnt; b_frame = frame_cnt;
    push_frame(2, 3);
    start_frame(2, 3);
    tick(); tick();
    chk("wait_fe_busy", busy, 1);
    chk("wait_fe_no_valid", reg_valid, 0);
    done_fe = 1'b1;
    tick();
    done_fe = 1'b0;
    chk("set0_starts", {reg_valid, 3'b0, reg_bbox_idx}, {1'b1, 3'b0, 5'd0});
    wait_idx(23);
    tick();
    chk("set0_done_st", done_registration, 1);
    done_fe = 1'b1;
    tick();
    done_fe = 1'b0;
    wait_frame(b_frame);
    chk("pending_dreg", dreg_cnt - b_dreg, 2);
    chk("pending_sb_empty", sb_q.size(), 0);

    // Three-cycle stall on idx 7.
    b_frame = frame_cnt;
    push_frame(1, 10);
    done_fe = 1'b1;
    start_frame(1, 10);
    wait_idx(6);
    tick();
    reg_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_hold", {reg_valid, 3'b0, reg_bbox_idx}, {1'b1, 3'b0, 5'd7});
      tick();
    end
    reg_ready = 1'b1;
    chk("stall_release", {reg_valid, 3'b0, reg_bbox_idx}, {1'b1, 3'b0, 5'd7});
    tick();
    chk("stall_next_idx", {reg_valid, 3'b0, reg_bbox_idx}, {1'b1, 3'b0, 5'd8});
    wait_frame(b_frame);
    chk("stall_sb_empty", sb_q.size(), 0);
    done_fe = 1'b0;
    tick();

    // Reset in the middle of set 0.
    b_dreg = dreg_cnt; b_frame = frame_cnt;
    push_frame(2, 5);
    done_fe = 1'b1;
    start_frame(2, 5);
    wait_idx(10);
    reset_N = 1'b0;
    #1;
    chk("abort_outputs", {reg_valid, done_registration, done_frame, busy, reg_timeout,
                          reg_bbox_idx, counter_set_registration}, 0);
    tick(); tick();
    sb_q.delete();
    done_fe = 1'b0;
    reset_N = 1'b1;
    tick(); tick(); tick();
    chk("abort_idle", busy, 0);
    chk("abort_no_dreg", dreg_cnt - b_dreg, 0);
    chk("abort_no_frame", frame_cnt - b_frame, 0);

`ifdef OFLOW_REG_TIMEOUT_EN
    // Watchdog: ready stuck low, REG_TIMEOUT = 4.
    b_dreg = dreg_cnt;
    reg_ready = 1'b0;
    done_fe = 1'b1;
    start_frame(1, 10);
    for (int c = 0; c < 50 && !reg_valid; c++) tick();
    for (int k = 0; k < 3; k++) begin
      chk("wd_not_yet", {reg_valid, reg_timeout}, 2'b10);
      tick();
    end
    chk("wd_last_stall", {reg_valid, reg_timeout}, 2'b10);
    tick();
    chk("wd_timeout", reg_timeout, 1);
    chk("wd_dreg", done_registration, 1);
    tick();
    chk("wd_sticky", {busy, reg_timeout}, 2'b01);
    chk("wd_dreg_count", dreg_cnt - b_dreg, 1);
    reg_ready = 1'b1;
    push_frame(1, 1);
    start_frame(1, 1);
    chk("wd_cleared", reg_timeout, 0);
    b_frame = frame_cnt;
    wait_frame(b_frame);
    done_fe = 1'b0;
`else
    // No watchdog: a long stall just waits.
    b_frame = frame_cnt;
    push_frame(1, 2);
    reg_ready = 1'b0;
    done_fe = 1'b1;
    start_frame(1, 2);
    for (int k = 0; k < 20; k++) tick();
    chk("nowd_valid_hold", {reg_valid, 3'b0, reg_bbox_idx}, {1'b1, 3'b0, 5'd0});
    chk("nowd_no_timeout", reg_timeout, 0);
    reg_ready = 1'b1;
    wait_frame(b_frame);
    chk("nowd_sb_empty", sb_q.size(), 0);
    done_fe = 1'b0;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
